// File: rtl/egress_packet_reader_pkg.sv
// Shared types and register map for the egress packet reader.
package egress_packet_reader_pkg;

    typedef logic [31:0] word_t;

    localparam word_t EOP_WORD = 32'h0;

    localparam logic [3:0] ADDR_DATA   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_PKTS   = 4'd2;
    localparam logic [3:0] ADDR_WORDS  = 4'd3;

    typedef enum logic [1:0] {EMPTY, FETCH, HOLD} egress_state_t;

endpackage

// File: rtl/egress_packet_reader_if.sv
// Avalon-MM read-only slave bus between the host and one egress packet reader.
interface egress_packet_reader_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              chipselect;
    logic              read;
    logic [3:0]        address;
    logic [DATA_W-1:0] readdata;

    modport master (output chipselect, output read, output address, input readdata);
    modport slave  (input chipselect, input read, input address, output readdata);
endinterface

// File: rtl/egress_packet_reader_stats.sv
// Popped-packet and popped-word counters; only instantiated under EGRESS_STATS_EN.
module egress_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        word_i,
    input  logic        eop_i,
    output logic [31:0] pkts_o,
    output logic [31:0] words_o
);
    logic [31:0] pkts_d, pkts_q, words_d, words_q;

    always_comb begin
        pkts_d  = pkts_q;
        words_d = words_q;
        if (clr_i) begin
            pkts_d  = '0;
            words_d = '0;
        end else begin
            if (eop_i)  pkts_d  = pkts_q + 32'd1;
            if (word_i) words_d = words_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkts_q  <= '0;
            words_q <= '0;
        end else begin
            pkts_q  <= pkts_d;
            words_q <= words_d;
        end
    end

    assign pkts_o  = pkts_q;
    assign words_o = words_q;
endmodule

// File: rtl/egress_packet_reader.sv
// Drains one switch output queue to the host over Avalon-MM with zero-bubble prefetch.
// Define EGRESS_STATS_EN to add packet/word counters at addresses 2 and 3.
module egress_packet_reader
    import egress_packet_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    egress_packet_reader_if.slave   bus,
    input  logic                    flush,
    input  logic [ADDR_W-1:0]       wr_ptr,
    output logic [ADDR_W-1:0]       ram_rdaddress,
    output logic                    ram_rden,
    input  logic [DATA_W-1:0]       ram_q
);
    egress_state_t     state_d, state_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [DATA_W-1:0] head_d, head_q;
    logic [DATA_W-1:0] readdata_d, readdata_q;
    logic              in_packet_d, in_packet_q;
    logic              underflow_d, underflow_q;

    logic [ADDR_W-1:0] avail;
    logic [ADDR_W:0]   occ_full;
    logic [12:0]       occ;
    logic [31:0]       status_word, stat_pkts, stat_words;
    logic [DATA_W-1:0] cur;
    logic              have, cur_valid, rd_sel, pop, issue, cur_eop;

    assign avail     = wr_ptr - rd_ptr_q;
    assign have      = (avail != '0);
    assign cur_valid = (state_q != EMPTY);
    // The RAM word is only live during FETCH; afterwards it is parked in head.
    assign cur       = (state_q == FETCH) ? ram_q : head_q;
    assign cur_eop   = (cur == DATA_W'(EOP_WORD));
    assign rd_sel    = bus.chipselect & bus.read;
    assign pop       = rd_sel & (bus.address == ADDR_DATA) & cur_valid & ~flush;
    assign issue     = ~flush & have & ((state_q == EMPTY) | pop);

    // Address/enable are combinational so ram_q lands in the FETCH cycle.
    assign ram_rden      = issue & ~reset;
    assign ram_rdaddress = rd_ptr_q;

    assign occ_full    = {1'b0, avail} + {{ADDR_W{1'b0}}, cur_valid};
    assign occ         = 13'(occ_full);
    assign status_word = {16'h0, underflow_q, in_packet_q, cur_valid, occ};

`ifdef EGRESS_STATS_EN
    logic eop_pop;
    assign eop_pop = pop & cur_eop & in_packet_q;

    egress_stats u_stats (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (flush),
        .word_i  (pop),
        .eop_i   (eop_pop),
        .pkts_o  (stat_pkts),
        .words_o (stat_words)
    );
`else
    assign stat_pkts  = '0;
    assign stat_words = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        head_d      = head_q;
        readdata_d  = readdata_q;
        in_packet_d = in_packet_q;
        underflow_d = underflow_q;
        if (flush) begin
            rd_ptr_d    = wr_ptr;
            state_d     = EMPTY;
            in_packet_d = 1'b0;
            underflow_d = 1'b0;
            if (rd_sel) readdata_d = '0;
        end else begin
            if (issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case (state_q)
                EMPTY: if (have) state_d = FETCH;
                FETCH: begin
                    if (pop) begin
                        state_d = have ? FETCH : EMPTY;
                    end else begin
                        head_d  = ram_q;
                        state_d = HOLD;
                    end
                end
                HOLD:    if (pop) state_d = have ? FETCH : EMPTY;
                default: state_d = EMPTY;
            endcase
            if (pop) begin
                if (!cur_eop && !in_packet_q) in_packet_d = 1'b1;
                else if (cur_eop && in_packet_q) in_packet_d = 1'b0;
            end
            if (rd_sel) begin
                case (bus.address)
                    ADDR_DATA: begin
                        readdata_d = cur_valid ? cur : '0;
                        if (!cur_valid) underflow_d = 1'b1;
                    end
                    ADDR_STATUS: begin
                        readdata_d  = DATA_W'(status_word);
                        underflow_d = 1'b0;
                    end
                    ADDR_PKTS:  readdata_d = DATA_W'(stat_pkts);
                    ADDR_WORDS: readdata_d = DATA_W'(stat_words);
                    default:    readdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            rd_ptr_q    <= '0;
            head_q      <= '0;
            readdata_q  <= '0;
            in_packet_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            head_q      <= head_d;
            readdata_q  <= readdata_d;
            in_packet_q <= in_packet_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.readdata = readdata_q;
endmodule
